ysyx_25020037_icache_assoc: RTL and testbench

YSYX_25020037_ICACHE_ASSOC -- requirements
Module: ysyx_25020037_icache_assoc

---
 rtl/ysyx_25020037_icache_assoc.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_25020037_icache_assoc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_icache_assoc.sv
// ysyx_25020037_icache_assoc: set-associative instruction cache refilled over AXI4 (bursts for 0xA/0xB regions, single beats elsewhere).
// Define YSYX_25020037_ICACHE_PERF_EN to add the perf_hit/perf_miss counters.
module ysyx_25020037_icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    output logic [31:0] inst,
    output logic        cpu_hit,
    input  logic        fence_i,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
`ifdef YSYX_25020037_ICACHE_PERF_EN
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
`endif
    input  logic [3:0]  rid
);
    localparam int OFFSET_WIDTH = $clog2(LINE_WORDS * 4);
    localparam int INDEX_WIDTH  = $clog2(SETS);
    localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WORD_WIDTH   = OFFSET_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, AREQ, RDATA} state_e;

    state_e                 state_q, state_d;
    logic                   valid_q [WAYS][SETS];
    logic                   valid_d [WAYS][SETS];
    logic                   lru_q [SETS];
    logic                   lru_d [SETS];
    logic [TAG_WIDTH-1:0]   tags_q [WAYS][SETS];
    logic [31:0]            data_q [WAYS][SETS][LINE_WORDS];
    logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
    logic [INDEX_WIDTH-1:0] req_idx_q, req_idx_d;
    logic [WORD_WIDTH-1:0]  beat_q, beat_d;
    logic                   way_q, way_d;
    logic                   burst_q, burst_d;
    logic                   err_q, err_d;
    logic                   fenced_q, fenced_d;

    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] idx;
    logic [WORD_WIDTH-1:0]  word;
    logic [WORD_WIDTH-1:0]  ar_word;
    logic                   hit_any, hit_way, victim;
    logic                   beat_fire, last_beat, good_fill;
    logic                   unused_ok;

    assign tag       = cpu_addr[31 -: TAG_WIDTH];
    assign idx       = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign word      = cpu_addr[2 +: WORD_WIDTH];
    assign unused_ok = ^{rid, cpu_addr[1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tags_q[w][idx] == tag) begin
                hit_any = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    assign cpu_hit = hit_any && state_q == IDLE;
    assign inst    = data_q[hit_way][idx][word];
    // The LRU bit names the most recently used way, so the victim is the other one.
    assign victim  = (WAYS == 1 || !valid_q[0][idx]) ? 1'b0 : !valid_q[WAYS-1][idx] ? 1'b1 : ~lru_q[idx];

    assign beat_fire = rvalid && rready;
    assign last_beat = beat_fire && (burst_q ? rlast : beat_q == WORD_WIDTH'(LINE_WORDS - 1));
    assign good_fill = last_beat && !err_q && rresp == 2'b00 && !fenced_q && !fence_i;

    assign arvalid = state_q == AREQ;
    assign rready  = state_q == RDATA;
    assign arid    = 4'd0;
    assign ar_word = burst_q ? '0 : beat_q;
    assign araddr  = arvalid ? {req_tag_q, req_idx_q, ar_word, 2'b00} : 32'd0;
    assign arlen   = (arvalid && burst_q) ? 8'(LINE_WORDS - 1) : 8'd0;
    assign arburst = (arvalid && burst_q) ? 2'b01 : 2'b00;
    assign arsize  = arvalid ? 3'b010 : 3'b000;

    always_comb begin
        state_d   = state_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        beat_d    = beat_q;
        way_d     = way_q;
        burst_d   = burst_q;
        err_d     = err_q;
        fenced_d  = fenced_q || (fence_i && state_q != IDLE);
        valid_d   = valid_q;
        lru_d     = lru_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid && !hit_any) begin
                    state_d   = AREQ;
                    req_tag_d = tag;
                    req_idx_d = idx;
                    way_d     = victim;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    fenced_d  = 1'b0;
                    burst_d   = cpu_addr[31:29] == 3'b101;
                end else if (cpu_valid) begin
                    lru_d[idx] = hit_way;
                end
            end
            AREQ: state_d = arready ? RDATA : AREQ;
            RDATA: begin
                if (beat_fire) begin
                    beat_d  = beat_q + 1'b1;
                    err_d   = err_q || rresp != 2'b00;
                    state_d = last_beat ? IDLE : burst_q ? RDATA : AREQ;
                    if (last_beat) valid_d[way_q][req_idx_q] = good_fill;
                    if (good_fill) lru_d[req_idx_q] = way_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fence_i) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    valid_d[w][s] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_tag_q <= '0;
            req_idx_q <= '0;
            beat_q    <= '0;
            way_q     <= 1'b0;
            burst_q   <= 1'b0;
            err_q     <= 1'b0;
            fenced_q  <= 1'b0;
            valid_q   <= '{default: '0};
            lru_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            beat_q    <= beat_d;
            way_q     <= way_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            fenced_q  <= fenced_d;
            valid_q   <= valid_d;
            lru_q     <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_fire) data_q[way_q][req_idx_q][beat_q] <= rdata;
        if (last_beat) tags_q[way_q][req_idx_q] <= req_tag_q;
    end

`ifdef YSYX_25020037_ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (state_q == IDLE && cpu_valid && hit_any) perf_hit_q <= perf_hit_q + 32'd1;
            if (state_q == IDLE && cpu_valid && !hit_any) perf_miss_q <= perf_miss_q + 32'd1;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif
endmodule

// File: tb/tb_ysyx_25020037_icache_assoc.sv
// tb_ysyx_25020037_icache_assoc: random fetches against a line-address LRU cache model and an AXI memory responder.
module tb_ysyx_25020037_icache_assoc;
    localparam int LINE_WORDS = 4;

    logic        clk, rst, cpu_valid, fence_i, cpu_hit;
    logic [31:0] cpu_addr, inst;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
`ifdef YSYX_25020037_ICACHE_PERF_EN
    logic [31:0] perf_hit, perf_miss;
`endif

    ysyx_25020037_icache_assoc dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .inst(inst),
        .cpu_hit(cpu_hit), .fence_i(fence_i), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
`ifdef YSYX_25020037_ICACHE_PERF_EN
        .perf_hit(perf_hit), .perf_miss(perf_miss),
`endif
        .rid(rid)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    // Reference cache: each set holds up to two line base addresses with last-use timestamps.
    bit          mvalid [2][8];
    logic [31:0] mline [2][8];
    int unsigned mtime [2][8];
    int unsigned now_t = 0;
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h7);
    endfunction

    function automatic int model_way(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < 2; w++)
            if (mvalid[w][s] && mline[w][s] == (a & ~32'hF)) return w;
        return -1;
    endfunction

    task automatic model_touch(input logic [31:0] a);
        int w = model_way(a);
        now_t++;
        if (w >= 0) mtime[w][set_of(a)] = now_t;
    endtask

    task automatic model_fill(input logic [31:0] a);
        int s = set_of(a);
        int w = !mvalid[0][s] ? 0 : !mvalid[1][s] ? 1 : (mtime[0][s] < mtime[1][s] ? 0 : 1);
        now_t++;
        mvalid[w][s] = 1;
        mline[w][s]  = a & ~32'hF;
        mtime[w][s]  = now_t;
    endtask

    task automatic model_fence();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) mvalid[w][s] = 0;
    endtask

    // AXI memory responder: random arready/rvalid gaps, optional error beat.
    logic [48:0] ar_log [$];
    logic [31:0] pend_a [$];
    bit          pend_l [$];
    int          line_beats = 0;
    bit          line_err = 0;
    bit          last_err = 0;
    int          done_cnt = 0;
    int          err_beat = -1;

    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_a.delete(); pend_l.delete();
                line_beats = 0; line_err = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
            end else begin
                rvalid = 0; rlast = 0; rresp = 0;
                if (pend_a.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rvalid = 1;
                    rdata  = mem_word(pend_a[0]);
                    rlast  = pend_l[0];
                    rresp  = (line_beats == err_beat) ? 2'b10 : 2'b00;
                    rid    = 4'($urandom);
                    if (rready) begin
                        void'(pend_a.pop_front());
                        void'(pend_l.pop_front());
                        line_err = line_err | (rresp != 2'b00);
                        line_beats++;
                        if (line_beats == LINE_WORDS) begin
                            last_err = line_err; line_err = 0; line_beats = 0;
                            err_beat = -1;
                            done_cnt++;
                        end
                    end
                end
                arready = arvalid && $urandom_range(0, 2) != 0;
                if (arvalid && arready) begin
                    ar_log.push_back({arid, arsize, arburst, arlen, araddr});
                    if (arburst == 2'b01) begin
                        for (int k = 0; k <= int'(arlen); k++) begin
                            pend_a.push_back(araddr + 32'(4 * k));
                            pend_l.push_back(k == int'(arlen));
                        end
                    end else begin
                        pend_a.push_back(araddr);
                        pend_l.push_back(1'b1);
                    end
                end
            end
        end
    end

    task automatic check_ars(input logic [31:0] a);
        logic [31:0] base = a & ~32'hF;
        bit burst = a[31:28] == 4'hA || a[31:28] == 4'hB;
        if (burst) begin
            check("ar_count_burst", ar_log.size(), 1);
            if (ar_log.size() >= 1) check("ar_burst", ar_log[0], {4'd0, 3'b010, 2'b01, 8'd3, base});
        end else begin
            check("ar_count_single", ar_log.size(), 4);
            for (int k = 0; k < ar_log.size() && k < 4; k++)
                check("ar_single", ar_log[k], {4'd0, 3'b010, 2'b00, 8'd0, base + 32'(4 * k)});
        end
    endtask

    task automatic fetch(input logic [31:0] a, input bit fence_plan, input int eb);
        bit done = 0;
        bit fenced;
        int base;
        err_beat = eb;
        cpu_addr = a;
        cpu_valid = 1;
        for (int att = 0; att < 4 && !done; att++) begin
            #2;
            if (model_way(a) >= 0) begin
                check("hit", cpu_hit, 1);
                check("inst", inst, mem_word({a[31:2], 2'b00}));
                model_touch(a);
                m_hits++;
                @(posedge clk); #1;
                done = 1;
            end else begin
                check("miss", cpu_hit, 0);
                m_misses++;
                base = done_cnt;
                fenced = 0;
                ar_log.delete();
                for (int c = 0; c < 300 && done_cnt == base; c++) begin
                    @(posedge clk); #1;
                    fence_i = 0;
                    if (done_cnt == base) begin
                        check("refill_hit_low", cpu_hit, 0);
                        if (fence_plan && c == 3) begin
                            fence_i = 1; fenced = 1; model_fence();
                        end
                    end
                end
                fence_i = 0;
                if (done_cnt == base) begin
                    check("refill_done", done_cnt, base + 1);
                    done = 1;
                end else begin
                    check_ars(a);
                    if (!fenced && !last_err) model_fill(a);
                    fence_plan = 0;
                end
            end
        end
        check("fetch_settled", done, 1);
        cpu_valid = 0;
    endtask

    initial begin
        logic [31:0] regions [4];
        logic [31:0] a;
        regions[0] = 32'hA0000000; regions[1] = 32'hB0001000;
        regions[2] = 32'h20000000; regions[3] = 32'h80000000;
        rst = 1; cpu_valid = 0; cpu_addr = 0; fence_i = 0;
        model_fence();
        repeat (3) @(posedge clk);
        #1;
        cpu_valid = 1; cpu_addr = 32'hA0000004;
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_arburst", arburst, 0);
        check("rst_arsize", arsize, 0);
        check("rst_arid", arid, 0);
        check("rst_hit", cpu_hit, 0);
`ifdef YSYX_25020037_ICACHE_PERF_EN
        check("rst_perf_hit", perf_hit, 0);
        check("rst_perf_miss", perf_miss, 0);
`endif
        cpu_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        fetch(32'hA0000004, 0, -1);
        fetch(32'h20000008, 0, -1);
        fetch(32'hA0000000, 0, -1);
        fetch(32'hA0000080, 0, -1);
        fetch(32'hA0000000, 0, -1);
        fetch(32'hA0000100, 0, -1);
        fetch(32'hA0000000, 0, -1);
        fetch(32'hA0000080, 0, -1);
        fetch(32'hA0000048, 1, -1);
        fetch(32'h20000014, 0, 1);
        fetch(32'h2000001C, 0, -1);
        for (int i = 0; i < 160; i++) begin
            a = regions[$urandom_range(0, 3)] | (32'($urandom_range(0, 2)) << 7)
                | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 19) == 0) begin
                fence_i = 1; model_fence();
                @(posedge clk); #1;
                fence_i = 0;
            end
            fetch(a, $urandom_range(0, 14) == 0, ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
`ifdef YSYX_25020037_ICACHE_PERF_EN
        check("perf_hit", perf_hit, m_hits);
        check("perf_miss", perf_miss, m_misses);
`endif
        fence_i = 1; model_fence();
        @(posedge clk); #1;
        fence_i = 0;
        cpu_addr = 32'hB0000370; cpu_valid = 1;
        for (int c = 0; c < 200 && line_beats < 2; c++) begin
            @(posedge clk); #1;
        end
        rst = 1;
        #1;
        check("midrst_arvalid", arvalid, 0);
        check("midrst_rready", rready, 0);
`ifdef YSYX_25020037_ICACHE_PERF_EN
        check("midrst_perf_hit", perf_hit, 0);
        check("midrst_perf_miss", perf_miss, 0);
`endif
        cpu_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_fence(); m_hits = 0; m_misses = 0; err_beat = -1;
        @(posedge clk); #1;
        fetch(32'hB0000370, 0, -1);
        fetch(32'hB0000374, 0, -1);
`ifdef YSYX_25020037_ICACHE_PERF_EN
        check("post_perf_hit", perf_hit, m_hits);
        check("post_perf_miss", perf_miss, m_misses);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
